// File: rtl/insn_loader_pkg.sv
// Shared types and constants for the instruction loader.
package insn_loader_pkg;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR
    } loader_state_e;

    localparam int BYTES_PER_INSN = 2;
    localparam int LEN_W          = 8 * BYTES_PER_INSN;

endpackage

// File: rtl/insn_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
module insn_ram #(
    parameter int ADDR_W = 10,
    parameter int INSN_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INSN_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INSN_W-1:0] rdata
);

    logic [INSN_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/insn_loader.sv
// Length-prefixed byte-stream program loader feeding the CPU instruction RAM.
// Define LOADER_CSUM_EN to require a trailing two's-complement checksum byte.
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int INSN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [INSN_W-1:0] insn,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output loader_state_e     state
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Byte channel: a byte moves on a clock edge where rx_valid && rx_ready.
    // rx_ready is a pure decode of the state and never looks at rx_valid.

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              cpu_rst_q, load_done_q, load_err_q;
    logic              ram_we;
    logic              xfer;
    logic              restart;
    logic [ADDR_W:0]   wc_inc;
    logic [LEN_W-1:0]  len_rx;
    logic              last_word;

`ifdef LOADER_CSUM_EN
    localparam loader_state_e AFTER_DATA = CSUM;
    logic [7:0] sum_q, sum_d;
    logic       csum_ok;
    assign csum_ok = (sum_q + rx_data) == 8'h00;
`else
    localparam loader_state_e AFTER_DATA = RUN;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign restart   = start && (state_q inside {IDLE, RUN, ERROR});
    assign wc_inc    = wc_q + (ADDR_W+1)'(1);
    assign len_rx    = {len_q[LEN_W-1:8], rx_data};
    assign last_word = 32'(wc_inc) == 32'(len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LEN_HI;
            LEN_HI:  if (xfer)  state_d = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_rx == '0)               state_d = AFTER_DATA;
                    else if (32'(len_rx) > DEPTH)   state_d = ERROR;
                    else                            state_d = DATA_HI;
                end
            end
            DATA_HI: if (xfer)  state_d = DATA_LO;
            DATA_LO: if (xfer)  state_d = last_word ? AFTER_DATA : DATA_HI;
`ifdef LOADER_CSUM_EN
            CSUM:    if (xfer)  state_d = csum_ok ? RUN : ERROR;
`endif
            RUN:     if (start) state_d = LEN_HI;
            ERROR:   if (start) state_d = LEN_HI;
            default:            state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM: rx_ready = 1'b1;
            default:                                rx_ready = 1'b0;
        endcase
        ram_we = (state_q == DATA_LO) && rx_valid;
    end

    always_comb begin
        len_d = len_q;
        hi_d  = hi_q;
        wc_d  = wc_q;
`ifdef LOADER_CSUM_EN
        sum_d = sum_q;
        if (restart) sum_d = 8'h00;
`endif
        if (restart) wc_d = '0;
        if (xfer) begin
            case (state_q)
                LEN_HI:  len_d[LEN_W-1:8] = rx_data;
                LEN_LO:  len_d[7:0]       = rx_data;
                DATA_HI: hi_d             = rx_data;
                DATA_LO: wc_d             = wc_inc;
                default: ;
            endcase
`ifdef LOADER_CSUM_EN
            if (state_q inside {DATA_HI, DATA_LO}) sum_d = sum_q + rx_data;
`endif
        end
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state transition that causes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            hi_q        <= '0;
            wc_q        <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef LOADER_CSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            len_q       <= len_d;
            hi_q        <= hi_d;
            wc_q        <= wc_d;
            cpu_rst_q   <= (state_d != RUN);
            load_done_q <= (state_d == RUN);
            load_err_q  <= (state_d == ERROR);
`ifdef LOADER_CSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    insn_ram #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wc_q[ADDR_W-1:0]),
        .wdata (INSN_W'({hi_q, rx_data})),
        .raddr (pc),
        .rdata (insn)
    );

    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = wc_q;
    assign state      = state_q;

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: vector table, hand sequences, random loads.
module tb_insn_loader;
    import insn_loader_pkg::*;

    localparam int ADDR_W = 10;
    localparam int INSN_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] pc = '0;
    logic [INSN_W-1:0] insn;
    logic              cpu_rst, load_done, load_err;
    logic [ADDR_W:0]   word_count;
    loader_state_e     state;

    insn_loader #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pc(pc), .insn(insn), .cpu_rst(cpu_rst),
        .load_done(load_done), .load_err(load_err), .word_count(word_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  tb_sum;
    logic [15:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] data_q [$];

    typedef struct {
        string       name;
        logic [15:0] len;
        int          nw;
        logic [15:0] w [3];
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_wc;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All driver tasks start and end 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took = 1'b0;
        int waited = 0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!took && waited < 50) begin
            took = rx_ready;
            @(posedge clk); #1;
            waited++;
        end
        rx_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_accept_timeout: got no transfer expected transfer of %0h", b);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
        tb_sum = tb_sum + w[15:8] + w[7:0];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tb_sum = 8'h00;
    endtask

    task automatic send_csum(input int gap);
`ifdef LOADER_CSUM_EN
        send_byte(8'h00 - tb_sum, gap);
`else
        if (gap < 0) send_byte(8'h00, 0);
`endif
    endtask

    task automatic model_write(input int idx, input logic [15:0] w);
        model_mem[idx]   = w;
        model_valid[idx] = 1'b1;
    endtask

    task automatic check_readback(input string name);
        int i = 0;
        while (exp_q.size() > 0) begin
            pc = ADDR_W'(i);
            #1;
            check(name, 32'(insn), 32'(exp_q.pop_front()));
            i++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [15:0] w;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
        check("rst_rx_ready", 32'(rx_ready), 32'(0));
        check("rst_load_done", 32'(load_done), 32'(0));
        check("rst_load_err", 32'(load_err), 32'(0));
        check("rst_word_count", 32'(word_count), 32'(0));
        check("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores the byte channel
        rx_data = 8'hAA; rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("idle_ignores_state", 32'(state), 32'(IDLE));
        check("idle_rx_ready", 32'(rx_ready), 32'(0));

        vecs[0] = '{name:"basic", len:16'd3, nw:3, w:'{16'h1234, 16'hABCD, 16'h0001},
                    gap:0, exp_done:1'b1, exp_err:1'b0, exp_wc:3};
        vecs[1] = '{name:"empty", len:16'd0, nw:0, w:'{16'h0, 16'h0, 16'h0},
                    gap:0, exp_done:1'b1, exp_err:1'b0, exp_wc:0};
        vecs[2] = '{name:"oversize", len:16'd1025, nw:0, w:'{16'h0, 16'h0, 16'h0},
                    gap:0, exp_done:1'b0, exp_err:1'b1, exp_wc:0};
        vecs[3] = '{name:"backpressure", len:16'd3, nw:3, w:'{16'h1234, 16'hABCD, 16'h0001},
                    gap:5, exp_done:1'b1, exp_err:1'b0, exp_wc:3};
        vecs[4] = '{name:"reload", len:16'd1, nw:1, w:'{16'hFFEE, 16'h0, 16'h0},
                    gap:0, exp_done:1'b1, exp_err:1'b0, exp_wc:1};

        for (int v = 0; v < 5; v++) begin
            pulse_start();
            check({vecs[v].name, "_start_state"}, 32'(state), 32'(LEN_HI));
            check({vecs[v].name, "_start_cpu_rst"}, 32'(cpu_rst), 32'(1));
            check({vecs[v].name, "_start_clears"}, 32'({load_done, load_err}), 32'(0));
            check({vecs[v].name, "_start_wc"}, 32'(word_count), 32'(0));
            send_byte(vecs[v].len[15:8], vecs[v].gap);
            check({vecs[v].name, "_midload_cpu_rst"}, 32'(cpu_rst), 32'(1));
            send_byte(vecs[v].len[7:0], vecs[v].gap);
            for (int i = 0; i < vecs[v].nw; i++) begin
                send_word(vecs[v].w[i], vecs[v].gap);
                model_write(i, vecs[v].w[i]);
                exp_q.push_back(vecs[v].w[i]);
            end
            if (!vecs[v].exp_err) send_csum(vecs[v].gap);
            check({vecs[v].name, "_load_done"}, 32'(load_done), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_load_err"}, 32'(load_err), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_cpu_rst"}, 32'(cpu_rst), 32'(!vecs[v].exp_done));
            check({vecs[v].name, "_rx_ready"}, 32'(rx_ready), 32'(0));
            check({vecs[v].name, "_word_count"}, 32'(word_count), 32'(vecs[v].exp_wc));
            check_readback({vecs[v].name, "_insn"});
        end

        // Start coincident with a byte transfer is ignored
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        rx_data = 8'h5A; rx_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; start = 1'b0;
        check("coincident_start_state", 32'(state), 32'(DATA_LO));
        send_byte(8'h5B, 0);
        tb_sum = 8'h5A + 8'h5B;
        send_csum(0);
        model_write(0, 16'h5A5B);
        check("coincident_done", 32'(load_done), 32'(1));
        pc = '0; #1;
        check("coincident_insn", 32'(insn), 32'(16'h5A5B));
        @(posedge clk); #1;

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_word(16'h1234, 0);
        model_write(0, 16'h1234);
        send_byte(8'hAB, 0);
        rst = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'(IDLE));
        check("midrst_cpu_rst", 32'(cpu_rst), 32'(1));
        check("midrst_rx_ready", 32'(rx_ready), 32'(0));
        check("midrst_wc", 32'(word_count), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rx_data = 8'h00; rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("midrst_needs_start", 32'(state), 32'(IDLE));
        pc = '0; #1;
        check("midrst_partial_ram", 32'(insn), 32'(16'h1234));
        @(posedge clk); #1;

`ifdef LOADER_CSUM_EN
        // Checksum good and bad
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
        send_byte(8'hD0, 0);
        model_write(0, 16'h1020);
        check("csum_good_done", 32'(load_done), 32'(1));
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
        send_byte(8'hD1, 0);
        check("csum_bad_err", 32'(load_err), 32'(1));
        check("csum_bad_cpu_rst", 32'(cpu_rst), 32'(1));
`endif

        // Full-depth load: N == 2**ADDR_W is legal
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < DEPTH; i++) begin
            w = 16'($urandom);
            send_word(w, 0);
            model_write(i, w);
        end
        send_csum(0);
        check("full_load_done", 32'(load_done), 32'(1));
        check("full_word_count", 32'(word_count), 32'(DEPTH));

        // Random loads with random gaps against the reference memory
        for (int r = 0; r < 20; r++) begin
            n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 16);
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(16'($urandom));
            pulse_start();
            send_byte(8'(n >> 8), $urandom_range(0, 3));
            send_byte(8'(n), $urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                send_word(data_q[i], $urandom_range(0, 3));
                model_write(i, data_q[i]);
                exp_q.push_back(data_q[i]);
            end
            send_csum($urandom_range(0, 3));
            check("rand_done", 32'(load_done), 32'(1));
            check("rand_cpu_rst", 32'(cpu_rst), 32'(0));
            check("rand_word_count", 32'(word_count), 32'(n));
            check_readback("rand_insn");
        end

        // Whole-memory sweep against the reference memory
        for (int i = 0; i < DEPTH; i++) begin
            if (model_valid[i]) begin
                pc = ADDR_W'(i);
                #1;
                check("sweep_insn", 32'(insn), 32'(model_mem[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/insn_loader.md
Name: insn_loader

Overview:
- Byte-stream program loader: the writer end of the CPU instruction fetch interface (pc -> insn).
- Receives a length-prefixed stream of 16-bit instruction words over a valid/ready byte channel and writes them into an internal 2**ADDR_W x 16 instruction RAM.
- Holds the CPU in reset during loading. Releases the CPU when loading finishes, then serves insn[pc] to it.
- Replaces the bench-side stdin preload with a synthesizable path; it sits between the host link (UART receiver) and cpu.

Parameters:
- ADDR_W, 10: instruction address width. RAM depth is 2**ADDR_W words.
- INSN_W, 16: instruction width. Fixed at two bytes per word; any other value is illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse: begin a new load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte. A transfer occurs when rx_valid && rx_ready.
- pc  in  ADDR_W  CPU fetch address.
- insn  out  INSN_W  instruction at pc (combinational read).
- cpu_rst  out  1  active-high reset to cpu.
- load_done  out  1  load completed successfully; CPU running.
- load_err  out  1  load aborted.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values: cpu_rst=1, rx_ready=0, load_done=0, load_err=0, word_count=0, state=IDLE. RAM contents are not reset.
- Stream format: LEN_HI, LEN_LO (N, 16-bit big-endian), then N words, each sent as hi byte then lo byte.
- IDLE: rx_ready=0; rx_valid is ignored. start -> LEN_HI; word_count cleared.
- LEN_HI / LEN_LO: rx_ready=1; capture the length bytes.
  - On LEN_LO accept with N==0 -> RUN.
  - On LEN_LO accept with N > 2**ADDR_W -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: rx_ready=1; latch the hi byte -> DATA_LO.
- DATA_LO: rx_ready=1. On accept:
  - RAM[word_count] <= {hi, rx_data}; word_count++.
  - If the incremented count == N, go to RUN (or CSUM when enabled); else go to DATA_HI.
- RUN: cpu_rst=0, load_done=1, rx_ready=0.
- ERROR: cpu_rst=1, load_err=1, rx_ready=0.
- All outputs are registered except insn and rx_ready, which decode the current state. cpu_rst falls on the clock edge after the final byte transfer. The CPU's first fetch is RAM[pc] with the written data visible (write-then-read in a later cycle).
- insn = RAM[pc] at all times. The CPU is in reset during loading, so reads during loading are harmless.
- start handling:
  - In RUN or ERROR: returns to LEN_HI next cycle; cpu_rst=1, load_done=0, load_err=0 in that same cycle.
  - In LEN_*, DATA_*, CSUM: ignored.
  - Coincident with a byte transfer: the byte is taken and start is ignored.
- Backpressure: rx_valid gaps of any length stall the FSM with no state change. rx_ready never depends on rx_valid.
- Reset mid-load: the FSM returns to IDLE immediately and cpu_rst=1. Partially written RAM contents remain.
- N == 2**ADDR_W is legal. word_count reaches 2**ADDR_W, which is why it is ADDR_W+1 bits wide; the write address uses the low ADDR_W bits.

Optional Feature:
- LOADER_CSUM_EN defined:
  - After the last word, state CSUM accepts one byte.
  - Required value: 8-bit wrap-around sum of all data bytes (length bytes excluded), so the check is (sum + rx_byte) mod 256 == 0. This two's-complement form is the only format.
  - Match -> RUN; mismatch -> ERROR.
  - N==0 also passes through CSUM, expecting a checksum byte of 0x00.
- LOADER_CSUM_EN undefined: no CSUM state and no sum register; the last DATA_LO or LEN_LO goes directly to RUN.

Decomposition:
- Package insn_loader_pkg:
  - state enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR.
  - constant BYTES_PER_INSN=2.
- Sub-module insn_ram:
  - single write port (we, waddr, wdata) on clk.
  - asynchronous read port (raddr -> rdata).
  - parameterised by ADDR_W and INSN_W.

Test Plan:
- Basic load, no CSUM: start; bytes 00 03 12 34 AB CD 00 01 -> RAM[0..2]=1234, ABCD, 0001; word_count=3; cpu_rst=0 one cycle after the last byte; pc=1 gives insn=ABCD.
- Empty program: start; bytes 00 00 -> RUN after the LEN_LO accept; load_done=1; word_count=0; no RAM writes.
- Oversize: ADDR_W=10; bytes 04 01 (N=1025) -> load_err=1, cpu_rst stays 1, rx_ready=0; later start -> LEN_HI with load_err=0.
- Backpressure and restart: same stream as the basic load with rx_valid low for 5 cycles between each byte -> identical RAM and outputs. In RUN, start -> cpu_rst=1 the next cycle; reload 00 01 FF EE -> RAM[0]=FFEE.
- Reset mid-load: drive rst=0 after 3 bytes -> IDLE and cpu_rst=1 asynchronously; a start pulse before the stream is required again.
- LOADER_CSUM_EN: 00 01 10 20 D0 -> RUN. The same stream with checksum D1 -> ERROR, load_err=1.
